bmult10x10_ppgen: RTL and testbench

//  Source end of the 10x10 Booth bit-heap path. Takes signed 10-bit operand pairs over valid/ready.

---
 rtl/bmult10x10_pkg.sv | 52 +++++
 rtl/bmult10x10_ppgen_enc.sv | 20 ++
 rtl/bmult10x10_ppgen.sv | 176 +++++++++++++++++
 tb/tb_bmult10x10_ppgen.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmult10x10_pkg.sv
// Shared types, constants and bit-heap placement helpers for the 10x10 radix-4 Booth multiplier.
package bmult10x10_pkg;

  localparam int unsigned OP_W    = 10;
  localparam int unsigned NUM_PP  = 5;
  localparam int unsigned PP_W    = 11;
  localparam int unsigned NUM_COL = 20;
  localparam int unsigned HEAP_W  = 66;

  localparam int unsigned COL_H [NUM_COL] = '{2, 1, 3, 2, 4, 3, 5, 4, 6, 5,
                                             6, 5, 4, 4, 3, 3, 2, 2, 1, 1};

  // Cancels the +2^(10+2i) each inverted PP sign bit contributes.
  localparam logic [NUM_COL-1:0] BOOTH_CONST = 20'hAAC00;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_dig_t;

  // Flat-heap offset of the first bit of column k.
  function automatic int unsigned col_off(int unsigned k);
    int unsigned off = 0;
    for (int unsigned c = 0; c < k; c++) off += COL_H[c];
    return off;
  endfunction

  // Flat-heap index of PP_i bit j; lower-indexed PPs sit below it in the column.
  function automatic int unsigned pp_pos(int unsigned i, int unsigned j);
    int unsigned k    = 2 * i + j;
    int unsigned rank = 0;
    for (int unsigned p = 0; p < i; p++) begin
      if (k - 2 * p <= PP_W - 1) rank++;
    end
    return col_off(k) + rank;
  endfunction

  // neg_i goes above every PP bit of column 2i.
  function automatic int unsigned neg_pos(int unsigned i);
    int unsigned rank = 0;
    for (int unsigned p = 0; p < NUM_PP; p++) begin
      if ((p <= i) && (2 * i - 2 * p <= PP_W - 1)) rank++;
    end
    return col_off(2 * i) + rank;
  endfunction

  function automatic int unsigned const_pos(int unsigned k);
    return col_off(k) + COL_H[k] - 1;
  endfunction

endpackage

// File: rtl/bmult10x10_ppgen_enc.sv
// Radix-4 Booth recoder: one overlapping multiplier triplet to a sign/magnitude digit.
module bmult_booth_enc
  import bmult10x10_pkg::*;
(
  input  logic [2:0]  bits_i,
  output booth_dig_t  dig_o
);

  always_comb begin
    dig_o = '0;
    case (bits_i)
      3'b001, 3'b010: dig_o.one = 1'b1;
      3'b011:         dig_o.two = 1'b1;
      3'b100:         begin dig_o.neg = 1'b1; dig_o.two = 1'b1; end
      3'b101, 3'b110: begin dig_o.neg = 1'b1; dig_o.one = 1'b1; end
      default:        dig_o = '0;  // 000 and 111 are zero with no negation bit
    endcase
  end

endmodule

// File: rtl/bmult10x10_ppgen.sv
// Booth partial-product bit-heap generator, 2-stage elastic pipeline.
// Optional BMULT_PPGEN_REF_EN adds out_ref_prod, the reference product carried alongside each heap.
module bmult10x10_ppgen
  import bmult10x10_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_a,
  input  logic [9:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_col0,
  output logic [0:0]       out_col1,
  output logic [2:0]       out_col2,
  output logic [1:0]       out_col3,
  output logic [3:0]       out_col4,
  output logic [2:0]       out_col5,
  output logic [4:0]       out_col6,
  output logic [3:0]       out_col7,
  output logic [5:0]       out_col8,
  output logic [4:0]       out_col9,
  output logic [5:0]       out_col10,
  output logic [4:0]       out_col11,
  output logic [3:0]       out_col12,
  output logic [3:0]       out_col13,
  output logic [2:0]       out_col14,
  output logic [2:0]       out_col15,
  output logic [1:0]       out_col16,
  output logic [1:0]       out_col17,
  output logic [0:0]       out_col18,
  output logic [0:0]       out_col19,
  output logic [CNT_W-1:0] tx_cnt
`ifdef BMULT_PPGEN_REF_EN
  ,
  output logic [19:0]      out_ref_prod
`endif
);

  logic                     s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [OP_W-1:0]          a_q, a_d;
  booth_dig_t [NUM_PP-1:0]  dig_q, dig_d, dig_enc;
  logic [HEAP_W-1:0]        heap_q, heap_d, heap_calc;
  logic [CNT_W-1:0]         tx_cnt_q, tx_cnt_d;
  logic [OP_W:0]            b_ext;
  logic                     s2_load_en, s1_adv, in_fire, out_fire;

  assign s2_load_en = !s2_valid_q || out_ready;
  assign s1_adv     = s1_valid_q && s2_load_en;
  assign in_ready   = !rst && (!s1_valid_q || s2_load_en);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = s2_valid_q && out_ready;

  assign b_ext = {in_b, 1'b0};

  for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_enc
    bmult_booth_enc u_enc (
      .bits_i (b_ext[2*gi +: 3]),
      .dig_o  (dig_enc[gi])
    );
  end

  for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_pp
    logic [PP_W-1:0] a_ext, mag, pp;
    assign a_ext = {a_q[OP_W-1], a_q};
    assign mag   = dig_q[gi].one ? a_ext :
                   dig_q[gi].two ? {a_ext[PP_W-2:0], 1'b0} : '0;
    assign pp    = dig_q[gi].neg ? ~mag : mag;
    for (genvar gj = 0; gj < PP_W; gj++) begin : g_bit
      if (gj == PP_W - 1) begin : g_msb
        assign heap_calc[pp_pos(gi, gj)] = ~pp[gj];
      end else begin : g_lsb
        assign heap_calc[pp_pos(gi, gj)] = pp[gj];
      end
    end
    assign heap_calc[neg_pos(gi)] = dig_q[gi].neg;
  end

  for (genvar gk = 0; gk < NUM_COL; gk++) begin : g_const
    if (BOOTH_CONST[gk]) begin : g_one
      assign heap_calc[const_pos(gk)] = 1'b1;
    end
  end

`ifdef BMULT_PPGEN_REF_EN
  logic [19:0] prod1_q, prod1_d, prod2_q, prod2_d, prod_in;
  assign prod_in      = $signed({{10{in_a[9]}}, in_a}) * $signed({{10{in_b[9]}}, in_b});
  assign out_ref_prod = prod2_q;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    dig_d      = dig_q;
    s2_valid_d = s2_valid_q;
    heap_d     = heap_q;
`ifdef BMULT_PPGEN_REF_EN
    prod1_d    = prod1_q;
    prod2_d    = prod2_q;
`endif
    if (s2_load_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        heap_d = heap_calc;
`ifdef BMULT_PPGEN_REF_EN
        prod2_d = prod1_q;
`endif
      end
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      a_d        = in_a;
      dig_d      = dig_enc;
`ifdef BMULT_PPGEN_REF_EN
      prod1_d    = prod_in;
`endif
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    tx_cnt_d = tx_cnt_q + CNT_W'(out_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      a_q        <= '0;
      dig_q      <= '0;
      heap_q     <= '0;
      tx_cnt_q   <= '0;
`ifdef BMULT_PPGEN_REF_EN
      prod1_q    <= '0;
      prod2_q    <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      a_q        <= a_d;
      dig_q      <= dig_d;
      heap_q     <= heap_d;
      tx_cnt_q   <= tx_cnt_d;
`ifdef BMULT_PPGEN_REF_EN
      prod1_q    <= prod1_d;
      prod2_q    <= prod2_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign tx_cnt    = tx_cnt_q;

  assign out_col0  = heap_q[col_off(0)  +: 2];
  assign out_col1  = heap_q[col_off(1)  +: 1];
  assign out_col2  = heap_q[col_off(2)  +: 3];
  assign out_col3  = heap_q[col_off(3)  +: 2];
  assign out_col4  = heap_q[col_off(4)  +: 4];
  assign out_col5  = heap_q[col_off(5)  +: 3];
  assign out_col6  = heap_q[col_off(6)  +: 5];
  assign out_col7  = heap_q[col_off(7)  +: 4];
  assign out_col8  = heap_q[col_off(8)  +: 6];
  assign out_col9  = heap_q[col_off(9)  +: 5];
  assign out_col10 = heap_q[col_off(10) +: 6];
  assign out_col11 = heap_q[col_off(11) +: 5];
  assign out_col12 = heap_q[col_off(12) +: 4];
  assign out_col13 = heap_q[col_off(13) +: 4];
  assign out_col14 = heap_q[col_off(14) +: 3];
  assign out_col15 = heap_q[col_off(15) +: 3];
  assign out_col16 = heap_q[col_off(16) +: 2];
  assign out_col17 = heap_q[col_off(17) +: 2];
  assign out_col18 = heap_q[col_off(18) +: 1];
  assign out_col19 = heap_q[col_off(19) +: 1];

endmodule

// File: tb/tb_bmult10x10_ppgen.sv
// Scoreboard bench for bmult10x10_ppgen: heap sums checked against A*B in issue order.
module tb_bmult10x10_ppgen;

  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [9:0] in_a, in_b;
  logic [1:0] out_col0;  logic [0:0] out_col1;  logic [2:0] out_col2;  logic [1:0] out_col3;
  logic [3:0] out_col4;  logic [2:0] out_col5;  logic [4:0] out_col6;  logic [3:0] out_col7;
  logic [5:0] out_col8;  logic [4:0] out_col9;  logic [5:0] out_col10; logic [4:0] out_col11;
  logic [3:0] out_col12; logic [3:0] out_col13; logic [2:0] out_col14; logic [2:0] out_col15;
  logic [1:0] out_col16; logic [1:0] out_col17; logic [0:0] out_col18; logic [0:0] out_col19;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]  tx_cnt4;
  logic [65:0] c4;
  logic        in_ready4, out_valid4;
`ifdef BMULT_PPGEN_REF_EN
  logic [19:0] out_ref_prod, ref4;
`endif

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] sb_exp, heap_sum;
  int hsum;
  logic [65:0] cols_all, snap;

  logic [9:0]  ca [7] = '{10'h001, 10'h200, 10'h1FF, 10'h1FF, 10'h3FF, 10'h200, 10'h200};
  logic [9:0]  cb [7] = '{10'h001, 10'h200, 10'h200, 10'h1FF, 10'h3FF, 10'h1FF, 10'h000};
  logic [19:0] ce [7] = '{20'h00001, 20'h40000, 20'hC0200, 20'h3FC01, 20'h00001, 20'hC0200,
                          20'h00000};

  always #5 clk = ~clk;

  bmult10x10_ppgen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_col0(out_col0), .out_col1(out_col1), .out_col2(out_col2), .out_col3(out_col3),
    .out_col4(out_col4), .out_col5(out_col5), .out_col6(out_col6), .out_col7(out_col7),
    .out_col8(out_col8), .out_col9(out_col9), .out_col10(out_col10), .out_col11(out_col11),
    .out_col12(out_col12), .out_col13(out_col13), .out_col14(out_col14),
    .out_col15(out_col15), .out_col16(out_col16), .out_col17(out_col17),
    .out_col18(out_col18), .out_col19(out_col19), .tx_cnt(tx_cnt)
`ifdef BMULT_PPGEN_REF_EN
    , .out_ref_prod(out_ref_prod)
`endif
  );

  // Narrow-counter copy fed the same stimulus; only its tx_cnt is examined.
  bmult10x10_ppgen #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_col0(c4[1:0]), .out_col1(c4[2:2]), .out_col2(c4[5:3]), .out_col3(c4[7:6]),
    .out_col4(c4[11:8]), .out_col5(c4[14:12]), .out_col6(c4[19:15]), .out_col7(c4[23:20]),
    .out_col8(c4[29:24]), .out_col9(c4[34:30]), .out_col10(c4[40:35]),
    .out_col11(c4[45:41]), .out_col12(c4[49:46]), .out_col13(c4[53:50]),
    .out_col14(c4[56:54]), .out_col15(c4[59:57]), .out_col16(c4[61:60]),
    .out_col17(c4[63:62]), .out_col18(c4[64:64]), .out_col19(c4[65:65]), .tx_cnt(tx_cnt4)
`ifdef BMULT_PPGEN_REF_EN
    , .out_ref_prod(ref4)
`endif
  );

  assign cols_all = {out_col19, out_col18, out_col17, out_col16, out_col15, out_col14,
                     out_col13, out_col12, out_col11, out_col10, out_col9, out_col8,
                     out_col7, out_col6, out_col5, out_col4, out_col3, out_col2,
                     out_col1, out_col0};

  always_comb begin
    hsum = 0;
    hsum += $countones(out_col0);        hsum += $countones(out_col1) << 1;
    hsum += $countones(out_col2) << 2;   hsum += $countones(out_col3) << 3;
    hsum += $countones(out_col4) << 4;   hsum += $countones(out_col5) << 5;
    hsum += $countones(out_col6) << 6;   hsum += $countones(out_col7) << 7;
    hsum += $countones(out_col8) << 8;   hsum += $countones(out_col9) << 9;
    hsum += $countones(out_col10) << 10; hsum += $countones(out_col11) << 11;
    hsum += $countones(out_col12) << 12; hsum += $countones(out_col13) << 13;
    hsum += $countones(out_col14) << 14; hsum += $countones(out_col15) << 15;
    hsum += $countones(out_col16) << 16; hsum += $countones(out_col17) << 17;
    hsum += $countones(out_col18) << 18; hsum += $countones(out_col19) << 19;
    heap_sum = hsum[19:0];
  end

  function automatic logic [19:0] prod(logic [9:0] a, logic [9:0] b);
    logic signed [19:0] r;
    r = $signed({{10{a[9]}}, a}) * $signed({{10{b[9]}}, b});
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on consume; reset drops in-flight heaps.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hs_cnt = 0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(prod(in_a, in_b));
      if (out_valid && out_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: heap sum %h with no pending pair", heap_sum);
        end else begin
          sb_exp = exp_q.pop_front();
          if (heap_sum !== sb_exp) begin
            errors++;
            $display("FAIL sb_heap_sum: got %h expected %h", heap_sum, sb_exp);
          end
`ifdef BMULT_PPGEN_REF_EN
          checks++;
          if (out_ref_prod !== sb_exp) begin
            errors++;
            $display("FAIL sb_ref_prod: got %h expected %h", out_ref_prod, sb_exp);
          end
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = 10'd5; in_b = 10'd7; out_ready = 1'b1;
    step(); step();
    checks += 5;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    if (tx_cnt !== '0) begin errors++; $display("FAIL rst_tx_cnt: got %0d exp 0", tx_cnt); end
    if (cols_all !== '0) begin errors++; $display("FAIL rst_cols: got %h exp 0", cols_all); end
    if (tx_cnt4 !== '0) begin errors++; $display("FAIL rst_tx_cnt4: got %0d exp 0", tx_cnt4); end
    rst = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_zero();
    in_valid = 1'b1; in_a = '0; in_b = '0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready: got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_lat1: got %b exp 0", out_valid); end
    step();
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_lat2: got %b exp 1", out_valid); end
    if (out_col0 !== 2'b00) begin errors++; $display("FAIL zero_col0: got %b exp 00", out_col0); end
    if (out_col10 !== 6'b100001) begin
      errors++; $display("FAIL zero_col10: got %b exp 100001", out_col10);
    end
    if (out_col19 !== 1'b1) begin errors++; $display("FAIL zero_col19: got %b exp 1", out_col19); end
    step();
  endtask

  task automatic test_corners();
    int idx_in = 0;
    int idx_out = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx_out < 7; c++) begin
      if (idx_in < 7) begin in_valid = 1'b1; in_a = ca[idx_in]; in_b = cb[idx_in]; end
      else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        if (heap_sum !== ce[idx_out]) begin
          errors++; $display("FAIL corner_%0d: got %h exp %h", idx_out, heap_sum, ce[idx_out]);
        end
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (idx_out != 7) begin errors++; $display("FAIL corner_count: got %0d exp 7", idx_out); end
    step();
  endtask

  task automatic test_stall();
    int acc = 0;
    bit have_snap = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_a = 10'(c + 10); in_b = 10'(-(c + 3));
      #1;
      if (in_ready) acc++;
      if (c >= 2) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b exp 0", c, in_ready); end
      end
      if (out_valid) begin
        if (have_snap) begin
          checks++;
          if (cols_all !== snap) begin
            errors++; $display("FAIL stall_stable_%0d: got %h exp %h", c, cols_all, snap);
          end
        end else begin
          snap = cols_all; have_snap = 1;
        end
      end
      step();
    end
    checks++;
    if (acc != 2) begin errors++; $display("FAIL stall_accepts: got %0d exp 2", acc); end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== (c < 2)) begin
        errors++; $display("FAIL stall_drain_%0d: got %b exp %b", c, out_valid, c < 2);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_a = 10'($urandom); in_b = 10'($urandom);
      step();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_a = 10'($urandom); in_b = 10'($urandom);
      #1;
      checks++;
      if (!(in_ready === 1'b1 && out_valid === 1'b1)) begin
        errors++; $display("FAIL b2b_full_%0d: got rdy=%b vld=%b exp 1 1", c, in_ready, out_valid);
      end
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== (c < 2)) begin
        errors++; $display("FAIL b2b_drain_%0d: got %b exp %b", c, out_valid, c < 2);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_a = 10'(c + 100); in_b = 10'(c + 7);
      step();
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre: got %b exp 1", out_valid); end
    rst = 1'b1; in_valid = 1'b1; in_a = 10'h155; in_b = 10'h0AB;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b exp 0", out_valid); end
    if (tx_cnt !== '0) begin errors++; $display("FAIL mrst_tx_cnt: got %0d exp 0", tx_cnt); end
    if (cols_all !== '0) begin errors++; $display("FAIL mrst_cols: got %h exp 0", cols_all); end
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_ignored: got %b exp 0", out_valid); end
    in_valid = 1'b1; in_a = 10'h3F0; in_b = 10'h021;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready: got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_lat1: got %b exp 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_lat2: got %b exp 1", out_valid); end
    step();
  endtask

  task automatic test_cnt_wrap();
    int acc = 0;
    pulse_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 17; c++) begin
      in_valid = 1'b1; in_a = 10'($urandom); in_b = 10'($urandom);
      #1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    checks += 3;
    if (tx_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap_tx_cnt4: got %0d exp 1", tx_cnt4); end
    if (tx_cnt !== CNT_W'(17)) begin errors++; $display("FAIL wrap_tx_cnt: got %0d exp 17", tx_cnt); end
    if (hs_cnt != 17) begin errors++; $display("FAIL wrap_handshakes: got %0d exp 17", hs_cnt); end
  endtask

  task automatic test_random();
    int issued = 0;
    pulse_reset();
    for (int c = 0; c < 60000 && issued < 20000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = 10'($urandom); in_b = 10'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) issued++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || out_valid); c++) step();
    checks += 5;
    if (issued != 20000) begin errors++; $display("FAIL rand_issued: got %0d exp 20000", issued); end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_lost: got %0d pending exp 0", exp_q.size());
    end
    if (hs_cnt != 20000) begin errors++; $display("FAIL rand_handshakes: got %0d exp 20000", hs_cnt); end
    if (tx_cnt !== CNT_W'(20000)) begin
      errors++; $display("FAIL rand_tx_cnt: got %0d exp 20000", tx_cnt);
    end
    if (tx_cnt4 !== 4'(20000 % 16)) begin
      errors++; $display("FAIL rand_tx_cnt4: got %0d exp %0d", tx_cnt4, 20000 % 16);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    test_reset();
    test_zero();
    test_corners();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_cnt_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
